// File: rtl/spi_slave_listener_if.sv
// SPI pin bundle between the host MCU link and the listener.
// Ports: spi_sclk, spi_cs_n, spi_mosi (host to FPGA), spi_miso (FPGA to host).
interface spi_slave_listener_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_sclk,
    output spi_cs_n,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_sclk,
    input  spi_cs_n,
    input  spi_mosi,
    output spi_miso
  );
endinterface

// File: rtl/spi_slave_listener.sv
// SPI mode-0 responder: oversamples the host pins, receives DATA_BITS-bit
// MSB-first words, publishes them on fpga_spi_data with a one-clk
// spi_listener_interrupt, and flags wrong-length frames with frame_error.
// Ports: clk, rst_n (async, active-low), spi (slave modport: sclk/cs_n/mosi
// in, miso out), tx_word (readback word), fpga_spi_data,
// spi_listener_interrupt, frame_error.
// Option: define SPI_MISO_READBACK_EN to shift tx_word out on spi_miso;
// otherwise spi_miso is tied low and no tx_shift register exists.
module spi_slave_listener #(
  parameter int DATA_BITS   = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_slave_listener_if.slave  spi,
  input  logic [DATA_BITS-1:0] tx_word,
  output logic [DATA_BITS-1:0] fpga_spi_data,
  output logic                 spi_listener_interrupt,
  output logic                 frame_error
);

  localparam int CW = $clog2(DATA_BITS + 2);
  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_BITS);
  localparam logic [CW-1:0] SAT  = CW'(DATA_BITS + 1);
  localparam logic [SW-1:0] SETL = SW'(SYNC_STAGES);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_d;
  logic                   cs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi.spi_sclk};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], spi.spi_cs_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi.spi_mosi};
      sclk_d <= sclk_q[SYNC_STAGES-1];
      cs_d   <= cs_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  // The cs_n chain resets high, so right after reset it reads "idle" even
  // if the pin is low mid-frame. Hold WAIT_IDLE until the chain has been
  // refilled from the pin before trusting cs_s.
  logic [SW-1:0] settle;
  logic          settled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle <= '0;
    end else if (settle != SETL) begin
      settle <= settle + 1'b1;
    end
  end

  assign settled = (settle == SETL);

  state_t state;
  state_t state_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT_IDLE: if (settled && cs_s) state_nx = IDLE;
      IDLE:      if (cs_fall)         state_nx = SHIFT;
      SHIFT:     if (cs_rise)         state_nx = IDLE;
      default:                        state_nx = WAIT_IDLE;
    endcase
  end

  logic start;
  logic shift_en;
  logic commit;
  logic fail;
  logic [CW-1:0] bit_cnt;

  // cs_rise wins over a coincident sclk_rise: that edge is dropped.
  always_comb begin
    start    = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    fail     = 1'b0;
    unique case (state)
      IDLE: start = cs_fall;
      SHIFT: begin
        shift_en = sclk_rise & ~cs_rise;
        commit   = cs_rise & (bit_cnt == FULL);
        fail     = cs_rise & (bit_cnt != FULL);
      end
      default: ;
    endcase
  end

  logic [DATA_BITS-1:0] shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift                  <= '0;
      bit_cnt                <= '0;
      fpga_spi_data          <= '0;
      spi_listener_interrupt <= 1'b0;
      frame_error            <= 1'b0;
    end else begin
      if (start) begin
        shift   <= '0;
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift <= {shift[DATA_BITS-2:0], mosi_s};
        if (bit_cnt != SAT) bit_cnt <= bit_cnt + 1'b1;
      end
      if (commit) fpga_spi_data <= shift;
      spi_listener_interrupt <= commit;
      frame_error            <= fail;
    end
  end

`ifdef SPI_MISO_READBACK_EN
  logic [DATA_BITS-1:0] tx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '0;
    end else if (start) begin
      tx_shift <= tx_word;
    end else if (state == SHIFT && sclk_fall) begin
      tx_shift <= {tx_shift[DATA_BITS-2:0], 1'b0};
    end
  end

  assign spi.spi_miso = (state == SHIFT) & tx_shift[DATA_BITS-1];
`else
  logic unused_tx;

  assign unused_tx    = ^{tx_word, sclk_fall};
  assign spi.spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_listener.sv
// Directed bench for spi_slave_listener: good, short, long, reset-mid-frame,
// back-to-back and readback frames with sclk = clk/8.
module tb_spi_slave_listener;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] tx_word;
  logic [23:0] data;
  logic        irq;
  logic        ferr;

  spi_slave_listener_if spi ();

  spi_slave_listener dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .spi                    (spi),
    .tx_word                (tx_word),
    .fpga_spi_data          (data),
    .spi_listener_interrupt (irq),
    .frame_error            (ferr)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;
  int irq_cnt  = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (irq) irq_cnt++;
    if (ferr) err_cnt++;
    if (irq && ferr) both_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: sim time expired, got no finish want finish");
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi.spi_cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n,
                            output logic [31:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      spi.spi_mosi = v[n-1-i];
      wait_clk(4);
      rx = {rx[30:0], spi.spi_miso};
      spi.spi_sclk = 1'b1;
      wait_clk(4);
      spi.spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_high();
    wait_clk(4);
    spi.spi_cs_n = 1'b1;
    spi.spi_mosi = 1'b0;
    wait_clk(10);
  endtask

  task automatic frame(input logic [31:0] v, input int n);
    logic [31:0] rx;
    cs_low();
    shift_bits(v, n, rx);
    cs_high();
  endtask

  task automatic test_reset();
    spi.spi_cs_n = 1'b1;
    spi.spi_sclk = 1'b0;
    spi.spi_mosi = 1'b0;
    tx_word = 24'h5A5A5A;
    rst_n = 1'b0;
    wait_clk(3);
    total++;
    if (data !== 24'h0) $display("FAIL reset_data: got %h want 000000", data);
    else pass_cnt++;
    total++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq);
    else pass_cnt++;
    total++;
    if (ferr !== 1'b0) $display("FAIL reset_ferr: got %b want 0", ferr);
    else pass_cnt++;
    total++;
    if (spi.spi_miso !== 1'b0)
      $display("FAIL reset_miso: got %b want 0", spi.spi_miso);
    else pass_cnt++;
    rst_n = 1'b1;
    wait_clk(6);
  endtask

  task automatic test_good_frame();
    int i0 = irq_cnt;
    int e0 = err_cnt;
    frame(32'h000002, 24);
    total++;
    if (data !== 24'h000002) $display("FAIL good_data: got %h want 000002", data);
    else pass_cnt++;
    total++;
    if (irq_cnt - i0 !== 1) $display("FAIL good_irq: got %0d want 1", irq_cnt - i0);
    else pass_cnt++;
    total++;
    if (err_cnt - e0 !== 0) $display("FAIL good_err: got %0d want 0", err_cnt - e0);
    else pass_cnt++;
  endtask

  task automatic test_short_frame();
    int i0 = irq_cnt;
    int e0 = err_cnt;
    frame(32'hFFFF, 16);
    total++;
    if (err_cnt - e0 !== 1) $display("FAIL short_err: got %0d want 1", err_cnt - e0);
    else pass_cnt++;
    total++;
    if (irq_cnt - i0 !== 0) $display("FAIL short_irq: got %0d want 0", irq_cnt - i0);
    else pass_cnt++;
    total++;
    if (data !== 24'h000002) $display("FAIL short_data: got %h want 000002", data);
    else pass_cnt++;
  endtask

  task automatic test_long_frame();
    int i0 = irq_cnt;
    int e0 = err_cnt;
    frame(32'h01FF_FFFF, 25);
    total++;
    if (err_cnt - e0 !== 1) $display("FAIL long_err: got %0d want 1", err_cnt - e0);
    else pass_cnt++;
    total++;
    if (data !== 24'h000002) $display("FAIL long_data: got %h want 000002", data);
    else pass_cnt++;
    i0 = irq_cnt;
    frame(32'hA5A5A5, 24);
    total++;
    if (data !== 24'hA5A5A5) $display("FAIL after_long_data: got %h want a5a5a5", data);
    else pass_cnt++;
    total++;
    if (irq_cnt - i0 !== 1) $display("FAIL after_long_irq: got %0d want 1", irq_cnt - i0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rx;
    int i0;
    int e0;
    cs_low();
    shift_bits(32'h2AB, 10, rx);
    rst_n = 1'b0;
    wait_clk(3);
    total++;
    if (data !== 24'h0) $display("FAIL midrst_data: got %h want 000000", data);
    else pass_cnt++;
    i0 = irq_cnt;
    e0 = err_cnt;
    rst_n = 1'b1;
    shift_bits(32'h1234, 14, rx);
    cs_high();
    total++;
    if (irq_cnt - i0 !== 0) $display("FAIL midrst_irq: got %0d want 0", irq_cnt - i0);
    else pass_cnt++;
    total++;
    if (err_cnt - e0 !== 0) $display("FAIL midrst_err: got %0d want 0", err_cnt - e0);
    else pass_cnt++;
    i0 = irq_cnt;
    frame(32'h123456, 24);
    total++;
    if (data !== 24'h123456) $display("FAIL midrst_next_data: got %h want 123456", data);
    else pass_cnt++;
    total++;
    if (irq_cnt - i0 !== 1) $display("FAIL midrst_next_irq: got %0d want 1", irq_cnt - i0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rx;
    int i0 = irq_cnt;
    int e0 = err_cnt;
    cs_low();
    shift_bits(32'h000001, 24, rx);
    wait_clk(4);
    spi.spi_cs_n = 1'b1;
    wait_clk(8);
    total++;
    if (data !== 24'h000001) $display("FAIL b2b_first_data: got %h want 000001", data);
    else pass_cnt++;
    spi.spi_cs_n = 1'b0;
    wait_clk(8);
    shift_bits(32'h000003, 24, rx);
    cs_high();
    total++;
    if (data !== 24'h000003) $display("FAIL b2b_second_data: got %h want 000003", data);
    else pass_cnt++;
    total++;
    if (irq_cnt - i0 !== 2) $display("FAIL b2b_irq: got %0d want 2", irq_cnt - i0);
    else pass_cnt++;
    total++;
    if (err_cnt - e0 !== 0) $display("FAIL b2b_err: got %0d want 0", err_cnt - e0);
    else pass_cnt++;
  endtask

  task automatic test_miso();
    logic [31:0] rx;
    logic [23:0] want;
`ifdef SPI_MISO_READBACK_EN
    want = 24'hC30FF0;
`else
    want = 24'h000000;
`endif
    tx_word = 24'hC30FF0;
    cs_low();
    shift_bits(32'h0F0F0F, 24, rx);
    cs_high();
    total++;
    if (rx[23:0] !== want) $display("FAIL miso_word: got %h want %h", rx[23:0], want);
    else pass_cnt++;
    total++;
    if (data !== 24'h0F0F0F) $display("FAIL miso_rx_data: got %h want 0f0f0f", data);
    else pass_cnt++;
    total++;
    if (spi.spi_miso !== 1'b0) $display("FAIL miso_idle: got %b want 0", spi.spi_miso);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_long_frame();
    test_reset_mid_frame();
    test_back_to_back();
    test_miso();
    total++;
    if (both_cnt !== 0) $display("FAIL irq_and_err_same_cycle: got %0d want 0", both_cnt);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
